// File: rtl/fetch_stage.sv
// Instruction fetch: one imem read per instruction, result held in a valid/ready slot for decode.
// Optional response watchdog (sticky fetch_error) is compiled in when FETCH_TIMEOUT_EN is defined.
module fetch_stage #(
  parameter logic [31:0] RESET_INSTR = 32'h00000013
`ifdef FETCH_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic [31:0] pc_add_4_in,
  output logic        pc_en,
  input  logic        flush,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_4,
  output logic        fetch_error
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  state_t      state_q, state_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] ipc4_q, ipc4_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] pend_pc4_q, pend_pc4_d;
  logic        timeout;

  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = pc_in;
  assign instr_valid    = instr_valid_q;
  assign instr_out      = instr_q;
  assign instr_pc       = ipc_q;
  assign instr_pc_4     = ipc4_q;

  always_comb begin
    state_d       = state_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    ipc_d         = ipc_q;
    ipc4_d        = ipc4_q;
    pend_pc_d     = pend_pc_q;
    pend_pc4_d    = pend_pc4_q;
    pc_en         = 1'b0;

    if (instr_valid_q && instr_ready) begin
      instr_valid_d = 1'b0;
    end

    if (flush) begin
      // Single pc_en level lets the PC take the branch target; any in-flight word is orphaned.
      pc_en         = 1'b1;
      instr_valid_d = 1'b0;
      unique case (state_q)
        IDLE:    state_d = IDLE;
        REQ:     state_d = imem_req_ready ? DRAIN : IDLE;
        WAIT:    state_d = imem_rsp_valid ? IDLE : DRAIN;
        DRAIN:   state_d = imem_rsp_valid ? IDLE : DRAIN;
        default: state_d = IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!instr_valid_q || instr_ready) begin
            state_d = REQ;
          end
        end
        REQ: begin
          if (imem_req_ready) begin
            pend_pc_d  = pc_in;
            pend_pc4_d = pc_add_4_in;
            state_d    = WAIT;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            pc_en         = 1'b1;
            instr_d       = imem_rsp_data;
            ipc_d         = pend_pc_q;
            ipc4_d        = pend_pc4_q;
            instr_valid_d = 1'b1;
            state_d       = IDLE;
          end else if (timeout) begin
            state_d = IDLE;
          end
        end
        DRAIN: begin
          if (imem_rsp_valid || timeout) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      instr_valid_q <= 1'b0;
      instr_q       <= RESET_INSTR;
      ipc_q         <= 32'h0;
      ipc4_q        <= 32'h0;
      pend_pc_q     <= 32'h0;
      pend_pc4_q    <= 32'h0;
    end else begin
      state_q       <= state_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      ipc_q         <= ipc_d;
      ipc4_q        <= ipc4_d;
      pend_pc_q     <= pend_pc_d;
      pend_pc4_q    <= pend_pc4_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // Fires in the TIMEOUT_CYCLES-th silent cycle; flush still takes precedence above.
  assign timeout = ((state_q == WAIT) || (state_q == DRAIN)) && !imem_rsp_valid &&
                   (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign fetch_error = err_q;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (((state_q == WAIT) || (state_q == DRAIN)) && !imem_rsp_valid) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (timeout && !flush) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  assign timeout     = 1'b0;
  assign fetch_error = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: cycle table from reset, then hand sequences for stalls, flushes, wrap and reset.
module tb_fetch_stage;

  logic        clock;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] pc_in;
  logic [31:0] pc_add_4_in;
  logic        pc_en;
  logic        flush;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_4;
  logic        fetch_error;

  assign pc_in       = pc;
  assign pc_add_4_in = pc + 32'd4;

  fetch_stage #(
    .RESET_INSTR(32'h00000013)
`ifdef FETCH_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clock(clock), .reset(reset), .pc_in(pc_in), .pc_add_4_in(pc_add_4_in),
    .pc_en(pc_en), .flush(flush),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_out(instr_out),
    .instr_pc(instr_pc), .instr_pc_4(instr_pc_4), .fetch_error(fetch_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] d;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  typedef struct {
    logic        mr;
    logic        dr;
    logic        fl;
    logic [31:0] tgt;
    logic        e_req;
    logic        e_pcen;
    logic        e_iv;
  } vec_t;

  exp_t        sbq[$];
  vec_t        tbl[22];
  int          nvec = 0;
  int          nbad = 0;
  int          hs_cnt = 0;
  int          pcen_cnt = 0;
  logic        hs_last = 1'b0;
  logic [31:0] last_hs_addr = 32'h0;
  logic [31:0] tgt = 32'h0;
  logic        slot_full = 1'b0;
  logic        outst = 1'b0;
  logic        discard = 1'b0;
  logic        mem_pend = 1'b0;
  logic        mem_hold = 1'b0;
  logic        force_data = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  int          mem_cnt = 0;
  int          rsp_lat = 1;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h0BAD0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 32'(act), 32'(exp));
  endtask

  task automatic clear_model();
    sbq.delete();
    pc = 32'h0; slot_full = 1'b0; outst = 1'b0; discard = 1'b0;
    mem_pend = 1'b0; mem_hold = 1'b0; force_data = 1'b0; rsp_lat = 1;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; flush = 1'b0;
  endtask

  // One clock: sample DUT mid-cycle, check against the protocol model, advance model after the edge.
  task automatic step();
    logic hs, rv, fl, cons, pe, ld;
    logic [31:0] ha;
    exp_t e;
    #4;
    hs   = imem_req_valid & imem_req_ready;
    ha   = imem_req_addr;
    rv   = imem_rsp_valid;
    fl   = flush;
    pe   = pc_en;
    cons = instr_valid & instr_ready;
    ld   = rv & ~discard & ~fl;
    chk1("instr_valid", instr_valid, slot_full);
    chk1("pc_en", pe, fl | (rv & ~discard));
    if (hs) chk("req_addr", ha, pc);
    if (cons && !fl) begin
      if (sbq.size() == 0) begin
        chk1("sb_nonempty", 1'b0, 1'b1);
      end else begin
        e = sbq.pop_front();
        chk("instr_out", instr_out, e.d);
        chk("instr_pc", instr_pc, e.pc);
        chk("instr_pc_4", instr_pc_4, e.pc4);
      end
    end
    if (pe) pcen_cnt++;
    if (hs) begin hs_cnt++; last_hs_addr = ha; end
    hs_last = hs;
    @(posedge clock);
    #1;
    if (rv) begin outst = 1'b0; discard = 1'b0; end
    if (fl) begin
      sbq.delete();
      slot_full = 1'b0;
      if (outst || hs) discard = 1'b1;
      if (hs) outst = 1'b1;
    end else begin
      if (cons) slot_full = 1'b0;
      if (hs) begin sbq.push_back('{memf(pc), pc, pc + 32'd4}); outst = 1'b1; end
      if (ld) slot_full = 1'b1;
    end
    if (pe) pc = fl ? tgt : pc + 32'd4;
    if (hs) begin mem_pend = 1'b1; mem_cnt = rsp_lat; mem_addr = ha; end
    imem_rsp_valid = 1'b0;
    if (mem_pend && !mem_hold) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = force_data ? 32'hDEADBEEF : memf(mem_addr);
        mem_pend       = 1'b0;
      end
    end
    flush = 1'b0;
  endtask

  task automatic run_until_hs(input int budget);
    logic got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      got = hs_last;
    end
    chk1("hs_wait", got, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        got;
    int          base;
    logic [31:0] to_addr;

    //              mr    dr    fl    tgt           req   pcen  iv
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 1'b1, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0};
    tbl[18] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1};
    tbl[19] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0};
    tbl[20] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0};
    tbl[21] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1};

    reset = 1'b1; imem_req_ready = 1'b0; instr_ready = 1'b0;
    clear_model();
    repeat (3) @(posedge clock);
    #4;
    chk1("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_instr_out", instr_out, 32'h00000013);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_instr_pc_4", instr_pc_4, 32'h0);
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk1("rst_pc_en", pc_en, 1'b0);
    chk1("rst_fetch_error", fetch_error, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Basic 0,4,8 stream with stalls, then flush coinciding with a response.
    for (int i = 0; i < 22; i++) begin
      imem_req_ready = tbl[i].mr;
      instr_ready    = tbl[i].dr;
      flush          = tbl[i].fl;
      tgt            = tbl[i].tgt;
      #3;
      chk1($sformatf("tbl%0d_req_valid", i), imem_req_valid, tbl[i].e_req);
      chk1($sformatf("tbl%0d_pc_en", i), pc_en, tbl[i].e_pcen);
      chk1($sformatf("tbl%0d_instr_valid", i), instr_valid, tbl[i].e_iv);
      step();
    end

    // Decode stalls for 10 cycles with a full slot.
    instr_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk1("stall_req_valid", imem_req_valid, 1'b0);
      chk("stall_instr_out", instr_out, memf(32'h204));
      chk("stall_instr_pc", instr_pc, 32'h204);
      step();
    end
    instr_ready = 1'b1;
    step();
    chk1("resume_req_valid", imem_req_valid, 1'b1);

    // Flush withdraws an unaccepted request, then memory stalls 5 cycles at 0x40.
    imem_req_ready = 1'b0; flush = 1'b1; tgt = 32'h40;
    step();
    chk1("withdraw_req_valid", imem_req_valid, 1'b0);
    step();
    base = hs_cnt;
    for (int i = 0; i < 5; i++) begin
      chk1("mstall_req_valid", imem_req_valid, 1'b1);
      chk("mstall_req_addr", imem_req_addr, 32'h40);
      step();
    end
    imem_req_ready = 1'b1;
    step();
    step();
    chk("mstall_handshakes", 32'(hs_cnt - base), 32'd1);

    // Flush in WAIT before a slow response; the late word must be discarded.
    rsp_lat = 4; force_data = 1'b1;
    run_until_hs(10);
    flush = 1'b1; tgt = 32'h100; base = pcen_cnt;
    repeat (4) step();
    chk1("drain_instr_valid", instr_valid, 1'b0);
    chk("drain_instr_out", instr_out, memf(32'h40));
    chk("drain_pc_en_count", 32'(pcen_cnt - base), 32'd1);
    rsp_lat = 1; force_data = 1'b0;
    run_until_hs(10);
    chk("post_flush_addr", last_hs_addr, 32'h100);

    // Fetch at the top of the address space; PC+4 wraps to zero.
    flush = 1'b1; tgt = 32'hFFFFFFFC; instr_ready = 1'b0;
    step();
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = instr_valid;
    end
    chk1("wrap_wait", got, 1'b1);
    chk("wrap_instr_pc", instr_pc, 32'hFFFFFFFC);
    chk("wrap_instr_pc_4", instr_pc_4, 32'h0);
    instr_ready = 1'b1;
    step();

    // Asynchronous reset in the middle of WAIT.
    rsp_lat = 3;
    run_until_hs(10);
    #2;
    reset = 1'b1;
    #1;
    chk1("arst_instr_valid", instr_valid, 1'b0);
    chk("arst_instr_out", instr_out, 32'h00000013);
    chk("arst_instr_pc", instr_pc, 32'h0);
    chk("arst_instr_pc_4", instr_pc_4, 32'h0);
    chk1("arst_req_valid", imem_req_valid, 1'b0);
    chk1("arst_pc_en", pc_en, 1'b0);
    chk1("arst_fetch_error", fetch_error, 1'b0);
    @(posedge clock);
    #1;
    clear_model();
    reset = 1'b0;
    run_until_hs(10);
    chk("post_reset_addr", last_hs_addr, 32'h0);
    repeat (4) step();

`ifdef FETCH_TIMEOUT_EN
    // Memory never answers: watchdog trips after 8 WAIT cycles and the same PC is retried.
    mem_hold = 1'b1;
    run_until_hs(10);
    to_addr = last_hs_addr;
    got = 1'b0;
    base = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      base++;
      got = fetch_error;
    end
    chk("timeout_cycles", 32'(base), 32'd8);
    chk1("timeout_error", fetch_error, 1'b1);
    run_until_hs(10);
    chk("retry_addr", last_hs_addr, to_addr);
    repeat (3) step();
    chk1("error_sticky", fetch_error, 1'b1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    clear_model();
    reset = 1'b0;
`else
    chk1("no_fetch_error", fetch_error, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
